// File: rtl/pong_match_sequencer.sv
// Match-flow controller: IDLE -> SERVE_WAIT -> PLAY -> POINT -> GAME_OVER, with BCD score keeping.
// Optional pause in PLAY when PONG_PAUSE_EN is defined.
module pong_match_sequencer #(
    parameter int unsigned WIN_SCORE   = 11,
    parameter int unsigned SERVE_DELAY = 60
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       start_pulse,
    input  logic       miss_left,
    input  logic       miss_right,
    output logic       run,
    output logic       ball_reset,
    output logic       serve_right,
    output logic [3:0] score_one_ones,
    output logic [3:0] score_one_tens,
    output logic [3:0] score_two_ones,
    output logic [3:0] score_two_tens,
    output logic [1:0] winner,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SERVE  = 3'd1,
        S_PLAY   = 3'd2,
        S_POINT  = 3'd3,
`ifdef PONG_PAUSE_EN
        S_OVER   = 3'd4,
        S_PAUSED = 3'd5
`else
        S_OVER   = 3'd4
`endif
    } state_t;

    typedef struct packed {
        logic [6:0] cnt;
        logic [3:0] tens;
        logic [3:0] ones;
    } score_t;

    localparam logic [6:0] LP_WIN = 7'(WIN_SCORE);
    localparam logic [7:0] LP_DLY = 8'(SERVE_DELAY - 1);

    state_t     r_state;
    state_t     w_next;
    score_t     r_p1;
    score_t     r_p2;
    logic [7:0] r_cnt;
    logic       r_serve_right;
    logic [1:0] r_winner;
    logic       w_win;

    // Binary count and BCD digits advance together; the count pins at 99.
    function automatic score_t f_inc(input score_t s);
        score_t r;
        r = s;
        if (s.cnt != 7'd99) begin
            r.cnt = s.cnt + 7'd1;
            if (s.ones == 4'd9) begin
                r.ones = '0;
                r.tens = s.tens + 4'd1;
            end else begin
                r.ones = s.ones + 4'd1;
            end
        end
        return r;
    endfunction

    assign w_win = (r_p1.cnt == LP_WIN) || (r_p2.cnt == LP_WIN);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_OVER: if (start_pulse) w_next = S_SERVE;
            S_SERVE:        if (r_cnt == '0) w_next = S_PLAY;
            S_PLAY: begin
                if (miss_left && miss_right)     w_next = S_SERVE;
                else if (miss_left || miss_right) w_next = S_POINT;
`ifdef PONG_PAUSE_EN
                else if (start_pulse)            w_next = S_PAUSED;
`endif
            end
            S_POINT:        w_next = w_win ? S_OVER : S_SERVE;
`ifdef PONG_PAUSE_EN
            S_PAUSED:       if (start_pulse) w_next = S_PLAY;
`endif
            default:        w_next = S_IDLE;
        endcase
    end

    always_comb begin
        run        = 1'b0;
        ball_reset = 1'b1;
        case (r_state)
            S_PLAY: begin
                run        = 1'b1;
                ball_reset = 1'b0;
            end
`ifdef PONG_PAUSE_EN
            S_PAUSED: ball_reset = 1'b0;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_p1          <= '0;
            r_p2          <= '0;
            r_cnt         <= '0;
            r_serve_right <= 1'b1;
            r_winner      <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_OVER: begin
                    if (start_pulse) begin
                        r_p1     <= '0;
                        r_p2     <= '0;
                        r_winner <= '0;
                        r_cnt    <= LP_DLY;
                    end
                end
                S_SERVE: if (r_cnt != '0) r_cnt <= r_cnt - 8'd1;
                S_PLAY: begin
                    if (miss_left && miss_right) begin
                        r_cnt <= LP_DLY;
                    end else if (miss_left) begin
                        r_p2          <= f_inc(r_p2);
                        r_serve_right <= 1'b0;
                    end else if (miss_right) begin
                        r_p1          <= f_inc(r_p1);
                        r_serve_right <= 1'b1;
                    end
                end
                S_POINT: begin
                    if (r_p1.cnt == LP_WIN)      r_winner <= 2'd1;
                    else if (r_p2.cnt == LP_WIN) r_winner <= 2'd2;
                    else                         r_cnt    <= LP_DLY;
                end
                default: ;
            endcase
        end
    end

    assign serve_right    = r_serve_right;
    assign score_one_ones = r_p1.ones;
    assign score_one_tens = r_p1.tens;
    assign score_two_ones = r_p2.ones;
    assign score_two_tens = r_p2.tens;
    assign winner         = r_winner;
    assign state          = r_state;

endmodule

// File: tb/tb_pong_match_sequencer.sv
// Directed bench for pong_match_sequencer (SERVE_DELAY=4, WIN_SCORE=11).
// Pause steps follow PONG_PAUSE_EN when it is defined for the build.
module tb_pong_match_sequencer;

    localparam int D = 4;
    localparam int W = 11;

    logic       clk = 1'b0;
    logic       clr_n;
    logic       start_pulse = 1'b0;
    logic       miss_left   = 1'b0;
    logic       miss_right  = 1'b0;
    logic       run, ball_reset, serve_right;
    logic [3:0] s1o, s1t, s2o, s2t;
    logic [1:0] winner;
    logic [2:0] state;

    int n_checks = 0;
    int n_fails  = 0;
    int exp1 = 0;
    int exp2 = 0;
    logic exp_sr = 1'b1;

    pong_match_sequencer #(.WIN_SCORE(W), .SERVE_DELAY(D)) dut (
        .clk(clk), .clr_n(clr_n), .start_pulse(start_pulse),
        .miss_left(miss_left), .miss_right(miss_right),
        .run(run), .ball_reset(ball_reset), .serve_right(serve_right),
        .score_one_ones(s1o), .score_one_tens(s1t),
        .score_two_ones(s2o), .score_two_tens(s2t),
        .winner(winner), .state(state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_scores(input string tag);
        check({tag, "_p1_ones"}, 32'(s1o), 32'(exp1 % 10));
        check({tag, "_p1_tens"}, 32'(s1t), 32'(exp1 / 10));
        check({tag, "_p2_ones"}, 32'(s2o), 32'(exp2 % 10));
        check({tag, "_p2_tens"}, 32'(s2t), 32'(exp2 / 10));
    endtask

    // Called on the first SERVE_WAIT cycle; checks it lasts exactly D cycles.
    task automatic serve_exact(input string tag);
        check({tag, "_serve_state"}, 32'(state), 32'd1);
        check({tag, "_serve_run"}, 32'(run), 32'd0);
        repeat (D - 1) tick();
        check({tag, "_serve_last"}, 32'(state), 32'd1);
        tick();
        check({tag, "_play_state"}, 32'(state), 32'd2);
        check({tag, "_play_run"}, 32'(run), 32'd1);
    endtask

    task automatic miss_point(input string tag, input logic l, input logic r, input bit serve);
        if (l) begin exp2++; exp_sr = 1'b0; end
        if (r) begin exp1++; exp_sr = 1'b1; end
        miss_left  = l;
        miss_right = r;
        tick();
        miss_left  = 1'b0;
        miss_right = 1'b0;
        check({tag, "_point_state"}, 32'(state), 32'd3);
        check({tag, "_point_run"}, 32'(run), 32'd0);
        check({tag, "_point_sr"}, 32'(serve_right), 32'(exp_sr));
        check({tag, "_point_winner"}, 32'(winner), 32'd0);
        check_scores(tag);
        tick();
        if (exp1 == W || exp2 == W) begin
            check({tag, "_over_state"}, 32'(state), 32'd4);
            check({tag, "_over_winner"}, 32'(winner), (exp1 == W) ? 32'd1 : 32'd2);
            check({tag, "_over_run"}, 32'(run), 32'd0);
            check({tag, "_over_ballrst"}, 32'(ball_reset), 32'd1);
        end else if (serve) begin
            serve_exact(tag);
        end else begin
            check({tag, "_to_serve"}, 32'(state), 32'd1);
        end
    endtask

    initial begin
        clr_n = 1'b0;
        repeat (2) tick();
        check("rst_state", 32'(state), 32'd0);
        check("rst_run", 32'(run), 32'd0);
        check("rst_ballrst", 32'(ball_reset), 32'd1);
        check("rst_sr", 32'(serve_right), 32'd1);
        check("rst_winner", 32'(winner), 32'd0);
        check_scores("rst");
        clr_n = 1'b1;
        tick();
        check("idle_hold", 32'(state), 32'd0);

        // Start: SERVE_WAIT next cycle, PLAY D cycles later.
        start_pulse = 1'b1;
        tick();
        start_pulse = 1'b0;
        serve_exact("start");
        check_scores("start");
        check("start_sr", 32'(serve_right), 32'd1);

        // Ten points to player one exercise the BCD carry.
        for (int i = 0; i < 10; i++) miss_point("p1", 1'b0, 1'b1, 1'b1);
        check("carry_tens", 32'(s1t), 32'd1);
        check("carry_ones", 32'(s1o), 32'd0);

        miss_point("p2a", 1'b1, 1'b0, 1'b1);

        // Simultaneous misses: no point, straight back to serve.
        miss_left  = 1'b1;
        miss_right = 1'b1;
        tick();
        miss_left  = 1'b0;
        miss_right = 1'b0;
        check("both_sr", 32'(serve_right), 32'd0);
        check_scores("both");
        serve_exact("both");

        // Start in PLAY: pause only when the feature is built in.
        start_pulse = 1'b1;
        tick();
        start_pulse = 1'b0;
`ifdef PONG_PAUSE_EN
        check("pause_state", 32'(state), 32'd5);
        check("pause_run", 32'(run), 32'd0);
        check("pause_ballrst", 32'(ball_reset), 32'd0);
        miss_left = 1'b1;
        tick();
        miss_left = 1'b0;
        check("pause_miss_state", 32'(state), 32'd5);
        check_scores("pause_miss");
        start_pulse = 1'b1;
        tick();
        start_pulse = 1'b0;
`else
        check("nopause_state", 32'(state), 32'd2);
        check("nopause_run", 32'(run), 32'd1);
`endif
        check("resume_state", 32'(state), 32'd2);
        check("resume_run", 32'(run), 32'd1);

        // Player two runs 1 -> 11 and wins while player one sits at 10.
        for (int i = 0; i < 10; i++) miss_point("p2", 1'b1, 1'b0, 1'b1);
        check("win_p2_tens", 32'(s2t), 32'd1);
        check("win_p2_ones", 32'(s2o), 32'd1);

        miss_right = 1'b1;
        tick();
        miss_right = 1'b0;
        check("over_ignore_miss", 32'(state), 32'd4);
        check_scores("over_hold");

        // Restart from GAME_OVER; start during SERVE_WAIT is ignored.
        start_pulse = 1'b1;
        tick();
        check("restart_state", 32'(state), 32'd1);
        check("restart_winner", 32'(winner), 32'd0);
        exp1 = 0;
        exp2 = 0;
        check_scores("restart");
        tick();
        start_pulse = 1'b0;
        check("serve_ignore_start", 32'(state), 32'd1);
        repeat (2) tick();
        check("serve_last2", 32'(state), 32'd1);
        tick();
        check("replay_state", 32'(state), 32'd2);

        // Reach 2-1 and assert reset in the middle of the serve delay.
        miss_point("r1", 1'b0, 1'b1, 1'b1);
        miss_point("r2", 1'b0, 1'b1, 1'b1);
        miss_point("r3", 1'b1, 1'b0, 1'b0);
        tick();
        check("pre_rst_state", 32'(state), 32'd1);
        check("pre_rst_p1", 32'(s1o), 32'd2);
        #1 clr_n = 1'b0;
        #1;
        exp1 = 0;
        exp2 = 0;
        check("arst_state", 32'(state), 32'd0);
        check("arst_run", 32'(run), 32'd0);
        check("arst_ballrst", 32'(ball_reset), 32'd1);
        check("arst_sr", 32'(serve_right), 32'd1);
        check("arst_winner", 32'(winner), 32'd0);
        check_scores("arst");
        tick();
        clr_n = 1'b1;
        tick();
        check("post_rst_idle", 32'(state), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/pong_match_sequencer.md
# pong_match_sequencer

Game-flow controller sitting between the debounced start button, the ball/paddle update logic and the score display. It sequences a match through idle, serve delay, rally, point and game-over phases. It gates the ball logic with `run` and `ball_reset`, picks the serve direction, and keeps both players' scores as BCD digits for the seven-segment controller. Clocked from the game clock; replaces the ad-hoc start toggle in the top level.

## Interface
- `WIN_SCORE`, 11: points needed to win; legal range 1..99.
- `SERVE_DELAY`, 60: game-clock cycles spent in SERVE_WAIT before a serve; legal range 1..255.
- `clk`  in  1  game clock.
- `clr_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `start_pulse`  in  1  single-cycle pulse from the debounced, edge-detected start button.
- `miss_left`  in  1  single-cycle pulse: ball passed the left wall. Player one missed; player two scores.
- `miss_right`  in  1  single-cycle pulse: ball passed the right wall. Player one scores.
- `run`  out  1  ball/paddle logic may advance.
- `ball_reset`  out  1  ball logic holds the ball at centre.
- `serve_right`  out  1  direction of the next serve: 1 = toward player two, 0 = toward player one.
- `score_one_ones`, `score_one_tens`, `score_two_ones`, `score_two_tens`  out  4 each  BCD score digits.
- `winner`  out  2  0 = none, 1 = player one, 2 = player two.
- `state`  out  3  current FSM state encoding, for debug and LEDs.

## Operation
- State encodings: IDLE=0, SERVE_WAIT=1, PLAY=2, POINT=3, GAME_OVER=4, PAUSED=5 (PAUSED only with the macro).
- IDLE: `run`=0, `ball_reset`=1.
  - `start_pulse` clears the scores and `winner`, loads the delay counter with SERVE_DELAY-1, and moves to SERVE_WAIT.
- SERVE_WAIT: `run`=0, `ball_reset`=1.
  - Counter decrements each cycle.
  - When the counter equals 0, moves to PLAY.
- PLAY: `run`=1, `ball_reset`=0.
  - `miss_left` alone: player two +1, `serve_right`←0, go to POINT.
  - `miss_right` alone: player one +1, `serve_right`←1, go to POINT.
  - Both misses in the same cycle: no score, `serve_right` unchanged, reload the counter, go to SERVE_WAIT.
- POINT (one cycle): `run`=0, `ball_reset`=1.
  - If either binary count equals WIN_SCORE: set `winner` and go to GAME_OVER.
  - Otherwise reload the counter and go to SERVE_WAIT.
- GAME_OVER: `run`=0, `ball_reset`=1; scores and `winner` hold.
  - `start_pulse` behaves exactly as it does in IDLE.
- Misses outside PLAY are ignored. `start_pulse` in SERVE_WAIT and POINT is ignored.
- Score arithmetic:
  - Each player has a 7-bit binary count, used for the win compare, plus BCD ones/tens digits.
  - Ones wraps 9→0 and carries into tens.
  - Count saturates at 99 (BCD 9/9); it cannot be reached when WIN_SCORE ≤ 99.
- Reset (asynchronous, at any time, including mid-rally or mid-delay):
  - state IDLE, `run` 0, `ball_reset` 1, `serve_right` 1.
  - All score digits and counts 0, `winner` 0, delay counter 0.

## Timing
- All outputs are registered; none are combinational from inputs.
- A miss in cycle n appears as:
  - updated score and `serve_right`, plus `run`=0, at n+1 (state POINT);
  - state SERVE_WAIT or GAME_OVER at n+2.
- SERVE_WAIT lasts exactly SERVE_DELAY cycles; `run` rises on the first PLAY cycle.
- `start_pulse` in cycle n in IDLE or GAME_OVER gives SERVE_WAIT at n+1 and PLAY at n+1+SERVE_DELAY.
- Inputs are synchronous to `clk`; a pulse held longer than one cycle is treated as one event per cycle.

## Configuration
- `PONG_PAUSE_EN` defined:
  - `start_pulse` in PLAY moves to PAUSED: `run`=0, `ball_reset`=0, so the ball freezes in place.
  - `start_pulse` in PAUSED returns to PLAY.
  - Misses are ignored while PAUSED.
- `PONG_PAUSE_EN` undefined: PAUSED does not exist and `start_pulse` in PLAY is ignored.

## Test plan
- Reset, then `start_pulse` with SERVE_DELAY=4:
  - `state` goes 0→1; `run` rises exactly 5 cycles after the pulse.
  - Scores 0/0/0/0, `serve_right`=1.
- In PLAY, pulse `miss_right` 10 times, each followed by a serve:
  - `score_one_tens`=1, `score_one_ones`=0; BCD carry is correct.
  - `serve_right`=1 after each point.
- WIN_SCORE=3: `miss_left` ×3:
  - `score_two_ones`=3, `winner`=2, `state`=4, `run`=0.
  - Next `start_pulse` clears the scores, `winner`=0, `state`=1.
- `miss_left` and `miss_right` in the same PLAY cycle:
  - Scores unchanged, next state SERVE_WAIT, `serve_right` unchanged.
- Assert `clr_n` low mid-SERVE_WAIT with score 2–1:
  - All outputs return to reset values immediately, without waiting for a `clk` edge.
- With `PONG_PAUSE_EN`: `start_pulse` in PLAY gives `state`=5, `run`=0, `ball_reset`=0.
  - `miss_left` while paused changes nothing.
  - Second `start_pulse` gives `state`=2, `run`=1.
  - Without the macro, the same stimulus leaves `state`=2.
